// File: rtl/game_session_ctrl.sv
// ----------------------------------------------------------------------------
// game_session_ctrl
//
// Session controller for an N-lane block-stacking game. Lane 0 drives the
// menu (player-count cursor, ENTER to start, ESC to abort). A countdown runs
// before play begins, each lane gets a one-cycle start pulse, and the session
// ends when at most one lane is still alive (or the single lane of a solo
// game tops out).
//
// Optional feature macro: SESSION_PAUSE_EN
//   defined   -> KEY_PAUSE from any active lane toggles PLAY <-> PAUSE
//   undefined -> KEY_PAUSE is ignored, PAUSE (state 3) is never entered
//
// Ports
//   i_clk         system clock (single domain)
//   i_rst_n       synchronous active-low reset
//   i_key         per-lane scancode, lane p at [8p+7:8p], 0 = no key
//   i_finish      per-lane level, lane's game has topped out
//   o_state       IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, OVER=4
//   o_cursor      menu selection (player count minus 1)
//   o_active      lanes taking part in the current session
//   o_start       one-cycle start pulse per lane on PLAY entry
//   o_freeze      per-lane hold request
//   o_winner      winning lane index
//   o_winner_vld  o_winner is meaningful (0 for solo or draw)
//
// Key events: a lane produces an event when its scancode is non-zero and
// differs from the value seen on the previous clock, so a held key yields a
// single event. The FSM acts on that event at the same edge.
// ----------------------------------------------------------------------------
module game_session_ctrl #(
    parameter int         N_PLAYERS = 2,
    parameter int         CD_CYCLES = 150000000,
    parameter logic [7:0] KEY_UP    = 8'h75,
    parameter logic [7:0] KEY_DOWN  = 8'h72,
    parameter logic [7:0] KEY_ENTER = 8'h5A,
    parameter logic [7:0] KEY_ESC   = 8'h76,
    parameter logic [7:0] KEY_PAUSE = 8'h4D
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [8*N_PLAYERS-1:0] i_key,
    input  logic [N_PLAYERS-1:0]   i_finish,
    output logic [2:0]             o_state,
    output logic [1:0]             o_cursor,
    output logic [N_PLAYERS-1:0]   o_active,
    output logic [N_PLAYERS-1:0]   o_start,
    output logic [N_PLAYERS-1:0]   o_freeze,
    output logic [1:0]             o_winner,
    output logic                   o_winner_vld
);

    localparam int                CNT_W      = (CD_CYCLES > 1) ? $clog2(CD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CD_LOAD    = CNT_W'(CD_CYCLES - 1);
    localparam logic [1:0]        CURSOR_MAX = 2'(N_PLAYERS - 1);

`ifdef SESSION_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_OVER      = 3'd4
    } state_t;

    // Registers
    state_t                 r_state;
    logic [1:0]             r_cursor;
    logic [N_PLAYERS-1:0]   r_active;
    logic [N_PLAYERS-1:0]   r_alive;
    logic [CNT_W-1:0]       r_cnt;
    logic [8*N_PLAYERS-1:0] r_key_prev;
    logic [N_PLAYERS-1:0]   r_start;
    logic [1:0]             r_winner;
    logic                   r_winner_vld;

    // Next-state values
    state_t                 w_state_nxt;
    logic [1:0]             w_cursor_nxt;
    logic [N_PLAYERS-1:0]   w_active_nxt;
    logic [N_PLAYERS-1:0]   w_alive_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [N_PLAYERS-1:0]   w_start_nxt;
    logic [1:0]             w_winner_nxt;
    logic                   w_winner_vld_nxt;

    // Decoded key events
    logic [N_PLAYERS-1:0]   w_evt;
    logic                   w_up;
    logic                   w_down;
    logic                   w_enter;
    logic                   w_esc;
    logic                   w_pause;
    logic [N_PLAYERS-1:0]   w_sel_mask;

    // Alive bookkeeping for the PLAY state
    logic [N_PLAYERS-1:0]   w_alive_after;
    logic [2:0]             w_alive_cnt;
    logic [1:0]             w_alive_idx;
    logic                   w_solo;

    always_comb begin
        w_evt      = '0;
        w_pause    = 1'b0;
        w_sel_mask = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            w_evt[p] = (i_key[8*p +: 8] != 8'h00) && (i_key[8*p +: 8] != r_key_prev[8*p +: 8]);
            // Pause may come from any lane that is part of the session.
            if (w_evt[p] && r_active[p] && (i_key[8*p +: 8] == KEY_PAUSE))
                w_pause = PAUSE_EN;
            // Lanes 0..cursor take part in the next session.
            w_sel_mask[p] = (p <= int'(r_cursor));
        end
    end

    // Menu/enter/esc come from lane 0 only.
    assign w_up    = w_evt[0] && (i_key[7:0] == KEY_UP);
    assign w_down  = w_evt[0] && (i_key[7:0] == KEY_DOWN);
    assign w_enter = w_evt[0] && (i_key[7:0] == KEY_ENTER);
    assign w_esc   = w_evt[0] && (i_key[7:0] == KEY_ESC);

    always_comb begin
        w_alive_after = r_alive & ~i_finish;
        w_alive_cnt   = 3'd0;
        w_alive_idx   = 2'd0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (w_alive_after[p]) begin
                w_alive_cnt = w_alive_cnt + 3'd1;
                w_alive_idx = 2'(p);
            end
        end
        // Active lanes are always the low bits, so a solo game is exactly lane 0.
        w_solo = (r_active == N_PLAYERS'(1));
    end

    // Next-state / output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_cursor_nxt     = r_cursor;
        w_active_nxt     = r_active;
        w_alive_nxt      = r_alive;
        w_cnt_nxt        = r_cnt;
        w_start_nxt      = '0;
        w_winner_nxt     = r_winner;
        w_winner_vld_nxt = r_winner_vld;

        case (r_state)
            S_IDLE: begin
                if (w_enter) begin
                    w_active_nxt = w_sel_mask;
                    w_cnt_nxt    = CD_LOAD;
                    w_state_nxt  = S_COUNTDOWN;
                end else if (w_up) begin
                    if (r_cursor != 2'd0)
                        w_cursor_nxt = r_cursor - 2'd1;
                end else if (w_down) begin
                    if (r_cursor < CURSOR_MAX)
                        w_cursor_nxt = r_cursor + 2'd1;
                end
            end

            S_COUNTDOWN: begin
                if (w_esc) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_PLAY;
                    w_start_nxt = r_active;
                    w_alive_nxt = r_active;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            S_PLAY: begin
                // ESC beats pause, pause beats finish in the same cycle;
                // a finish level still present after resume is taken then.
                if (w_esc) begin
                    w_state_nxt = S_IDLE;
                end else if (w_pause) begin
                    w_state_nxt = S_PAUSE;
                end else begin
                    w_alive_nxt = w_alive_after;
                    if (w_alive_cnt == 3'd0) begin
                        // Solo top-out or simultaneous finish: no winner.
                        w_state_nxt      = S_OVER;
                        w_winner_nxt     = 2'd0;
                        w_winner_vld_nxt = 1'b0;
                    end else if ((w_alive_cnt == 3'd1) && !w_solo) begin
                        w_state_nxt      = S_OVER;
                        w_winner_nxt     = w_alive_idx;
                        w_winner_vld_nxt = 1'b1;
                    end
                end
            end

`ifdef SESSION_PAUSE_EN
            S_PAUSE: begin
                if (w_esc)
                    w_state_nxt = S_IDLE;
                else if (w_pause)
                    w_state_nxt = S_PLAY;
            end
`endif

            S_OVER: begin
                if (w_enter || w_esc)
                    w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Every entry into IDLE wipes the session; the cursor is kept.
        if ((w_state_nxt == S_IDLE) && (r_state != S_IDLE)) begin
            w_active_nxt     = '0;
            w_alive_nxt      = '0;
            w_cnt_nxt        = '0;
            w_start_nxt      = '0;
            w_winner_nxt     = 2'd0;
            w_winner_vld_nxt = 1'b0;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cursor     <= 2'd0;
            r_active     <= '0;
            r_alive      <= '0;
            r_cnt        <= '0;
            r_key_prev   <= '0;
            r_start      <= '0;
            r_winner     <= 2'd0;
            r_winner_vld <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cursor     <= w_cursor_nxt;
            r_active     <= w_active_nxt;
            r_alive      <= w_alive_nxt;
            r_cnt        <= w_cnt_nxt;
            r_key_prev   <= i_key;
            r_start      <= w_start_nxt;
            r_winner     <= w_winner_nxt;
            r_winner_vld <= w_winner_vld_nxt;
        end
    end

    always_comb begin
        o_freeze = '1;
        for (int p = 0; p < N_PLAYERS; p++)
            o_freeze[p] = !((r_state == S_PLAY) && r_active[p] && r_alive[p]);
    end

    assign o_state      = r_state;
    assign o_cursor     = r_cursor;
    assign o_active     = r_active;
    assign o_start      = r_start;
    assign o_winner     = r_winner;
    assign o_winner_vld = r_winner_vld;

endmodule

// File: tb/tb_game_session_ctrl.sv
module tb_game_session_ctrl;

    localparam logic [7:0] K_UP    = 8'h75;
    localparam logic [7:0] K_DOWN  = 8'h72;
    localparam logic [7:0] K_ENTER = 8'h5A;
    localparam logic [7:0] K_ESC   = 8'h76;
    localparam logic [7:0] K_PAUSE = 8'h4D;

    logic        clk;
    logic        rst_n;
    logic [15:0] key;
    logic [1:0]  finish;
    logic [2:0]  state;
    logic [1:0]  cursor;
    logic [1:0]  active;
    logic [1:0]  start;
    logic [1:0]  freeze;
    logic [1:0]  winner;
    logic        winner_vld;

    int n_checks = 0;
    int n_pass   = 0;

    game_session_ctrl #(
        .N_PLAYERS(2),
        .CD_CYCLES(4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_key        (key),
        .i_finish     (finish),
        .o_state      (state),
        .o_cursor     (cursor),
        .o_active     (active),
        .o_start      (start),
        .o_freeze     (freeze),
        .o_winner     (winner),
        .o_winner_vld (winner_vld)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clean key event: released for a cycle, then pressed for one edge.
    task automatic press(input int lane, input logic [7:0] code);
        key = '0;
        tick();
        key[lane*8 +: 8] = code;
        tick();
        key = '0;
    endtask

    // ENTER then 4 countdown edges; returns in the first PLAY cycle.
    task automatic start_session();
        press(0, K_ENTER);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        key    = '0;
        finish = '0;
        tick();
        tick();
        n_checks++; if (state !== 3'd0)     $display("FAIL reset_state got=%0d exp=0", state);       else n_pass++;
        n_checks++; if (cursor !== 2'd0)    $display("FAIL reset_cursor got=%0d exp=0", cursor);     else n_pass++;
        n_checks++; if (active !== 2'b00)   $display("FAIL reset_active got=%b exp=00", active);     else n_pass++;
        n_checks++; if (start !== 2'b00)    $display("FAIL reset_start got=%b exp=00", start);       else n_pass++;
        n_checks++; if (winner !== 2'd0)    $display("FAIL reset_winner got=%0d exp=0", winner);     else n_pass++;
        n_checks++; if (winner_vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", winner_vld);    else n_pass++;
        n_checks++; if (freeze !== 2'b11)   $display("FAIL reset_freeze got=%b exp=11", freeze);     else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cursor();
        press(0, K_UP);
        n_checks++; if (cursor !== 2'd0) $display("FAIL cursor_sat_low got=%0d exp=0", cursor); else n_pass++;
        // Held DOWN key is a single step.
        key[7:0] = K_DOWN;
        repeat (10) tick();
        key = '0;
        n_checks++; if (cursor !== 2'd1) $display("FAIL cursor_hold got=%0d exp=1", cursor); else n_pass++;
        press(0, K_DOWN);
        n_checks++; if (cursor !== 2'd1) $display("FAIL cursor_sat_high got=%0d exp=1", cursor); else n_pass++;
        press(0, K_UP);
        n_checks++; if (cursor !== 2'd0) $display("FAIL cursor_up got=%0d exp=0", cursor); else n_pass++;
        press(0, K_DOWN);
        n_checks++; if (cursor !== 2'd1) $display("FAIL cursor_down got=%0d exp=1", cursor); else n_pass++;
        // Menu keys from lane 1 are ignored.
        press(1, K_UP);
        n_checks++; if (cursor !== 2'd1) $display("FAIL cursor_lane1 got=%0d exp=1", cursor); else n_pass++;
        n_checks++; if (state !== 3'd0) $display("FAIL cursor_state got=%0d exp=0", state); else n_pass++;
    endtask

    task automatic test_countdown();
        press(0, K_ENTER);
        n_checks++; if (state !== 3'd1)   $display("FAIL cd_enter_state got=%0d exp=1", state); else n_pass++;
        n_checks++; if (active !== 2'b11) $display("FAIL cd_active got=%b exp=11", active);     else n_pass++;
        n_checks++; if (start !== 2'b00)  $display("FAIL cd_start0 got=%b exp=00", start);      else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (state !== 3'd1)  $display("FAIL cd_state_%0d got=%0d exp=1", i, state); else n_pass++;
            n_checks++; if (start !== 2'b00) $display("FAIL cd_start_%0d got=%b exp=00", i, start); else n_pass++;
        end
        tick();
        n_checks++; if (state !== 3'd2)   $display("FAIL cd_play got=%0d exp=2", state);        else n_pass++;
        n_checks++; if (start !== 2'b11)  $display("FAIL cd_pulse got=%b exp=11", start);       else n_pass++;
        n_checks++; if (freeze !== 2'b00) $display("FAIL cd_freeze got=%b exp=00", freeze);     else n_pass++;
        tick();
        n_checks++; if (start !== 2'b00)  $display("FAIL cd_pulse_end got=%b exp=00", start);   else n_pass++;
    endtask

    task automatic test_winner();
        finish = 2'b10;
        tick();
        finish = 2'b00;
        n_checks++; if (state !== 3'd4)      $display("FAIL win_state got=%0d exp=4", state);     else n_pass++;
        n_checks++; if (winner !== 2'd0)     $display("FAIL win_lane got=%0d exp=0", winner);     else n_pass++;
        n_checks++; if (winner_vld !== 1'b1) $display("FAIL win_vld got=%b exp=1", winner_vld);   else n_pass++;
        n_checks++; if (freeze !== 2'b11)    $display("FAIL win_freeze got=%b exp=11", freeze);   else n_pass++;
        tick();
        n_checks++; if (winner_vld !== 1'b1) $display("FAIL win_hold got=%b exp=1", winner_vld);  else n_pass++;
        press(0, K_ENTER);
        n_checks++; if (state !== 3'd0)      $display("FAIL win_idle got=%0d exp=0", state);      else n_pass++;
        n_checks++; if (winner_vld !== 1'b0) $display("FAIL win_clear got=%b exp=0", winner_vld); else n_pass++;
        n_checks++; if (active !== 2'b00)    $display("FAIL win_active got=%b exp=00", active);   else n_pass++;
        n_checks++; if (cursor !== 2'd1)     $display("FAIL win_cursor got=%0d exp=1", cursor);   else n_pass++;
    endtask

    task automatic test_draw();
        start_session();
        n_checks++; if (state !== 3'd2) $display("FAIL draw_play got=%0d exp=2", state); else n_pass++;
        finish = 2'b11;
        tick();
        finish = 2'b00;
        n_checks++; if (state !== 3'd4)      $display("FAIL draw_state got=%0d exp=4", state);   else n_pass++;
        n_checks++; if (winner_vld !== 1'b0) $display("FAIL draw_vld got=%b exp=0", winner_vld); else n_pass++;
        press(0, K_ESC);
        n_checks++; if (state !== 3'd0) $display("FAIL draw_esc got=%0d exp=0", state); else n_pass++;
    endtask

    task automatic test_pause();
        start_session();
        press(1, K_PAUSE);
`ifdef SESSION_PAUSE_EN
        n_checks++; if (state !== 3'd3)   $display("FAIL pause_state got=%0d exp=3", state);   else n_pass++;
        n_checks++; if (freeze !== 2'b11) $display("FAIL pause_freeze got=%b exp=11", freeze); else n_pass++;
        finish = 2'b01;
        tick();
        finish = 2'b00;
        n_checks++; if (state !== 3'd3) $display("FAIL pause_finish got=%0d exp=3", state); else n_pass++;
        press(1, K_PAUSE);
        n_checks++; if (state !== 3'd2) $display("FAIL pause_resume got=%0d exp=2", state); else n_pass++;
`else
        n_checks++; if (state !== 3'd2)   $display("FAIL nopause_state got=%0d exp=2", state);   else n_pass++;
        n_checks++; if (freeze !== 2'b00) $display("FAIL nopause_freeze got=%b exp=00", freeze); else n_pass++;
`endif
        finish = 2'b01;
        tick();
        finish = 2'b00;
        n_checks++; if (state !== 3'd4)      $display("FAIL pause_over got=%0d exp=4", state);    else n_pass++;
        n_checks++; if (winner !== 2'd1)     $display("FAIL pause_win got=%0d exp=1", winner);    else n_pass++;
        n_checks++; if (winner_vld !== 1'b1) $display("FAIL pause_vld got=%b exp=1", winner_vld); else n_pass++;
        press(0, K_ESC);
        n_checks++; if (state !== 3'd0) $display("FAIL pause_esc got=%0d exp=0", state); else n_pass++;
    endtask

    task automatic test_esc_priority();
        start_session();
        key = '0;
        tick();
        key[7:0] = K_ESC;
        finish   = 2'b11;
        tick();
        key    = '0;
        finish = 2'b00;
        n_checks++; if (state !== 3'd0)      $display("FAIL escp_state got=%0d exp=0", state);   else n_pass++;
        n_checks++; if (winner_vld !== 1'b0) $display("FAIL escp_vld got=%b exp=0", winner_vld); else n_pass++;
        n_checks++; if (active !== 2'b00)    $display("FAIL escp_active got=%b exp=00", active); else n_pass++;
    endtask

    task automatic test_reset_in_countdown();
        press(0, K_ENTER);
        tick();
        tick();
        // Counter is now 1.
        rst_n = 1'b0;
        tick();
        n_checks++; if (state !== 3'd0)   $display("FAIL rcd_state got=%0d exp=0", state); else n_pass++;
        n_checks++; if (start !== 2'b00)  $display("FAIL rcd_start got=%b exp=00", start); else n_pass++;
        n_checks++; if (cursor !== 2'd0)  $display("FAIL rcd_cursor got=%0d exp=0", cursor); else n_pass++;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (start !== 2'b00) $display("FAIL rcd_nopulse_%0d got=%b exp=00", i, start); else n_pass++;
            n_checks++; if (state !== 3'd0)  $display("FAIL rcd_idle_%0d got=%0d exp=0", i, state);   else n_pass++;
        end
    endtask

    task automatic test_solo();
        start_session();
        n_checks++; if (state !== 3'd2)   $display("FAIL solo_play got=%0d exp=2", state);     else n_pass++;
        n_checks++; if (active !== 2'b01) $display("FAIL solo_active got=%b exp=01", active);  else n_pass++;
        n_checks++; if (start !== 2'b01)  $display("FAIL solo_start got=%b exp=01", start);    else n_pass++;
        n_checks++; if (freeze !== 2'b10) $display("FAIL solo_freeze got=%b exp=10", freeze);  else n_pass++;
        finish = 2'b01;
        tick();
        finish = 2'b00;
        n_checks++; if (state !== 3'd4)      $display("FAIL solo_over got=%0d exp=4", state);    else n_pass++;
        n_checks++; if (winner !== 2'd0)     $display("FAIL solo_win got=%0d exp=0", winner);    else n_pass++;
        n_checks++; if (winner_vld !== 1'b0) $display("FAIL solo_vld got=%b exp=0", winner_vld); else n_pass++;
        press(0, K_ENTER);
        n_checks++; if (state !== 3'd0) $display("FAIL solo_idle got=%0d exp=0", state); else n_pass++;
    endtask

    initial begin
        rst_n  = 1'b0;
        key    = '0;
        finish = '0;
        test_reset();
        test_cursor();
        test_countdown();
        test_winner();
        test_draw();
        test_pause();
        test_esc_priority();
        test_reset_in_countdown();
        test_solo();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_session_ctrl.md
GAME_SESSION_CTRL -- requirements
Module: game_session_ctrl

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 2, number of game lanes (legal 1..4).
REQ-002 SHALL have parameter CD_CYCLES, default 150000000, countdown length in clocks (>=1).
REQ-003 SHALL have parameters KEY_UP 8'h75, KEY_DOWN 8'h72, KEY_ENTER 8'h5A, KEY_ESC 8'h76, KEY_PAUSE 8'h4D, the scancodes the block acts on.
REQ-004 i_clk  in  1  system clock; one clock domain; reset is synchronous and active-low.
REQ-005 i_rst_n  in  1  synchronous active-low reset.
REQ-006 i_key  in  8*N_PLAYERS  current scancode per player, lane p at bits [8p+7:8p], 0 = none.
REQ-007 i_finish  in  N_PLAYERS  level, lane p's game has topped out.
REQ-008 o_state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, OVER=4.
REQ-009 o_cursor  out  2  menu selection, player count minus 1.
REQ-010 o_active  out  N_PLAYERS  lanes in the current session.
REQ-011 o_start  out  N_PLAYERS  one-cycle start pulse per lane.
REQ-012 o_freeze  out  N_PLAYERS  level, lane's game must hold.
REQ-013 o_winner  out  2 / o_winner_vld  out  1  session result.

Function
REQ-014 Key event for lane p SHALL be i_key[p] != 0 and != its registered previous value; holding a key SHALL yield one event only.
REQ-015 The FSM SHALL act on a key event at the same clock edge that samples it; outputs reflect it after that edge.
REQ-016 Menu, enter and esc SHALL be taken from lane 0 only; pause SHALL be taken from any active lane.
REQ-017 IDLE: UP/DOWN SHALL move o_cursor by 1, saturating at 0 and N_PLAYERS-1; ENTER SHALL latch o_active = low (o_cursor+1) bits set, load counter with CD_CYCLES-1, go COUNTDOWN.
REQ-018 COUNTDOWN: counter SHALL decrement each clock; at 0 SHALL go PLAY and pulse o_start for all o_active lanes in that same transition cycle; ESC SHALL go IDLE with no start pulse.
REQ-019 PLAY: a lane with i_finish high SHALL be cleared from an internal alive mask; alive lanes SHALL be o_active at PLAY entry.
REQ-020 PLAY, 1 active lane: its finish SHALL go OVER with o_winner=0, o_winner_vld=0 (solo, no winner).
REQ-021 PLAY, >1 active lanes: when exactly one lane remains alive SHALL go OVER with o_winner=that lane, o_winner_vld=1.
REQ-022 Simultaneous finish of all remaining alive lanes SHALL go OVER with o_winner_vld=0 (draw).
REQ-023 ESC in PLAY, PAUSE or COUNTDOWN SHALL go IDLE; ESC has priority over pause and finish in the same cycle.
REQ-024 PAUSE: PAUSE key SHALL return to PLAY; i_finish SHALL be ignored while paused.
REQ-025 OVER: ENTER or ESC SHALL go IDLE; o_winner/o_winner_vld SHALL hold until IDLE re-entry clears them.
REQ-026 o_freeze[p] SHALL be high when lane p is not active, not alive, or state is not PLAY.
REQ-027 o_cursor SHALL be retained across sessions; o_active SHALL clear on IDLE entry.

Reset
REQ-028 On i_rst_n low at a clock edge: state IDLE, o_cursor 0, o_active 0, alive mask 0, counter 0, key history 0, o_start 0, o_winner 0, o_winner_vld 0; o_freeze all ones.
REQ-029 Reset mid-session SHALL abort without any o_start pulse.

Configuration
REQ-030 Macro SESSION_PAUSE_EN defined: PAUSE state and KEY_PAUSE handling SHALL be present.
REQ-031 SESSION_PAUSE_EN undefined: KEY_PAUSE SHALL be ignored; state 3 SHALL be unreachable; all else unchanged.

Verification
REQ-032 N_PLAYERS=2, CD_CYCLES=4: hold DOWN 10 cycles, then ENTER -> o_cursor=1 (single step), COUNTDOWN 4 cycles, o_start=2'b11 for one cycle, state PLAY.
REQ-033 Cursor at 0, UP event -> o_cursor stays 0; N_PLAYERS=2, two DOWN events -> o_cursor=1.
REQ-034 2P PLAY, i_finish=2'b10 -> OVER, o_winner=0, o_winner_vld=1, o_freeze=2'b11; ENTER -> IDLE, o_winner_vld=0.
REQ-035 2P PLAY, i_finish=2'b11 same cycle -> OVER, o_winner_vld=0.
REQ-036 SESSION_PAUSE_EN: lane 1 sends PAUSE -> state 3, o_freeze=2'b11, i_finish=2'b01 ignored; PAUSE again -> PLAY; without macro PAUSE -> state stays 2.
REQ-037 Reset asserted in COUNTDOWN at counter 1 -> IDLE next cycle, o_start never pulses.
